// File: rtl/fpm_pkg.sv
// Shared definitions for the sequential half-precision multiplier controller.
// FPM_NAN_INF_EN selects IEEE special-value handling for exponent-31 inputs.
package fpm_pkg;

    localparam int unsigned EXP_W = 5;
    localparam int unsigned MAN_W = 10;
    localparam int unsigned BIAS  = 15;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXP_ADD  = 3'd1,
        EXP_BIAS = 3'd2,
        MANT     = 3'd3,
        NORM     = 3'd4
    } fpm_state_t;

    localparam logic [14:0] INF_MAG = 15'h7C00;
    localparam logic [15:0] QNAN    = 16'h7E00;

endpackage

// File: rtl/fpm_exp_alu.sv
// Shared signed exponent adder/subtractor: add_sub=1 adds, add_sub=0 subtracts.
module fpm_exp_alu #(
    parameter int unsigned W = 7
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                add_sub,
    output logic signed [W-1:0] y
);

    always_comb begin
        y = add_sub ? (a + b) : (a - b);
    end

endmodule

// File: rtl/fpm_seq_ctrl.sv
// Sequential half-precision multiplier controller with fixed 14-cycle latency.
// Define FPM_NAN_INF_EN to resolve NaN/infinity inputs in the NORM step.
module fpm_seq_ctrl
    import fpm_pkg::*;
#(
    parameter int unsigned EXP_W = fpm_pkg::EXP_W,
    parameter int unsigned MAN_W = fpm_pkg::MAN_W,
    parameter int unsigned BIAS  = fpm_pkg::BIAS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [EXP_W+MAN_W:0]     op_a,
    input  logic [EXP_W+MAN_W:0]     op_b,
    output logic                     busy,
    output logic                     done,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned DW = 1 + EXP_W + MAN_W;
    localparam int unsigned MW = MAN_W + 1;
    localparam int unsigned PW = 2 * MW;
    localparam int unsigned EW = EXP_W + 2;
    localparam int unsigned CW = $clog2(MW);

    fpm_state_t state_q, state_d;

    logic                 sign_q;
    logic [EXP_W-1:0]     ea_q, eb_q;
    logic [MW-1:0]        ma_q, mb_q;
    logic                 zero_q;
    logic signed [EW-1:0] e_q;
    logic [CW-1:0]        cnt_q;
    logic [PW-1:0]        prod_q;
    logic                 done_q;
    logic [DW-1:0]        result_q;
    logic                 ovf_q, unf_q;
`ifdef FPM_NAN_INF_EN
    logic                 nan_q, inf_q;
`endif

    logic signed [EW-1:0] alu_a, alu_b, alu_y;
    logic                 alu_add;

    logic                 norm_hi;
    logic [MAN_W-1:0]     man_n;
    logic signed [EW-1:0] e_n;
    logic [DW-1:0]        res_n;
    logic                 ovf_n, unf_n;

    // The single exponent unit is time-shared: ea+eb first, then e-BIAS.
    always_comb begin
        alu_a   = e_q;
        alu_b   = EW'(BIAS);
        alu_add = 1'b0;
        if (state_q == EXP_ADD) begin
            alu_a   = $signed({2'b00, ea_q});
            alu_b   = $signed({2'b00, eb_q});
            alu_add = 1'b1;
        end
    end

    fpm_exp_alu #(.W(EW)) u_exp_alu (
        .a       (alu_a),
        .b       (alu_b),
        .add_sub (alu_add),
        .y       (alu_y)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = EXP_ADD;
            EXP_ADD:  state_d = EXP_BIAS;
            EXP_BIAS: state_d = MANT;
            MANT:     if (cnt_q == CW'(MW - 1)) state_d = NORM;
            NORM:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        norm_hi = prod_q[PW-1];
        man_n   = norm_hi ? prod_q[PW-2 -: MAN_W] : prod_q[PW-3 -: MAN_W];
        e_n     = norm_hi ? (e_q + $signed(EW'(1))) : e_q;
        res_n   = {sign_q, e_n[EXP_W-1:0], man_n};
        ovf_n   = 1'b0;
        unf_n   = 1'b0;
`ifdef FPM_NAN_INF_EN
        if (nan_q || (inf_q && zero_q)) begin
            res_n = QNAN;
        end else if (inf_q) begin
            res_n = {sign_q, INF_MAG};
        end else
`endif
        if (zero_q) begin
            res_n = {sign_q, {(DW-1){1'b0}}};
        end else if (e_n >= $signed(EW'(2**EXP_W - 1))) begin
            res_n = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_n = 1'b1;
        end else if (e_n <= $signed(EW'(0))) begin
            res_n = {sign_q, {(DW-1){1'b0}}};
            unf_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q   <= 1'b0;
            ea_q     <= '0;
            eb_q     <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            zero_q   <= 1'b0;
            e_q      <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
`ifdef FPM_NAN_INF_EN
            nan_q    <= 1'b0;
            inf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sign_q <= op_a[DW-1] ^ op_b[DW-1];
                        ea_q   <= op_a[DW-2 -: EXP_W];
                        eb_q   <= op_b[DW-2 -: EXP_W];
                        ma_q   <= {1'b1, op_a[MAN_W-1:0]};
                        mb_q   <= {1'b1, op_b[MAN_W-1:0]};
                        zero_q <= (op_a[DW-2 -: EXP_W] == '0) || (op_b[DW-2 -: EXP_W] == '0);
                        ovf_q  <= 1'b0;
                        unf_q  <= 1'b0;
`ifdef FPM_NAN_INF_EN
                        nan_q  <= ((op_a[DW-2 -: EXP_W] == '1) && (op_a[MAN_W-1:0] != '0)) ||
                                  ((op_b[DW-2 -: EXP_W] == '1) && (op_b[MAN_W-1:0] != '0));
                        inf_q  <= (op_a[DW-2 -: EXP_W] == '1) || (op_b[DW-2 -: EXP_W] == '1);
`endif
                    end
                end
                EXP_ADD: begin
                    e_q <= alu_y;
                end
                EXP_BIAS: begin
                    e_q    <= alu_y;
                    cnt_q  <= '0;
                    prod_q <= '0;
                end
                MANT: begin
                    if (mb_q[cnt_q]) begin
                        prod_q <= prod_q + (PW'(ma_q) << cnt_q);
                    end
                    cnt_q <= cnt_q + CW'(1);
                end
                NORM: begin
                    result_q <= res_n;
                    ovf_q    <= ovf_n;
                    unf_q    <= unf_n;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_fpm_seq_ctrl.sv
// Self-checking bench for fpm_seq_ctrl: cycle-level reference model plus directed vectors.
// Build with FPM_NAN_INF_EN defined to exercise the special-value cases.
module tb_fpm_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        busy, done, overflow, underflow;
    logic [15:0] result;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned n_done_seen = 0;

    fpm_seq_ctrl #(.EXP_W(5), .MAN_W(10), .BIAS(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // Product computed directly as an integer multiply, then normalized by magnitude.
    function automatic void fp_mul(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] r, output logic ov, output logic un);
        int          ea, eb, e;
        int unsigned p;
        logic        s;
        logic [9:0]  m;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        s  = a[15] ^ b[15];
        p  = (1024 + int'(a[9:0])) * (1024 + int'(b[9:0]));
        e  = ea + eb - 15;
        if (p >= (1 << 21)) begin
            m = 10'((p >> 11) & 1023);
            e = e + 1;
        end else begin
            m = 10'((p >> 10) & 1023);
        end
        ov = 1'b0;
        un = 1'b0;
`ifdef FPM_NAN_INF_EN
        if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0) ||
            ((ea == 31 || eb == 31) && (ea == 0 || eb == 0))) begin
            r = 16'h7E00;
            return;
        end
        if (ea == 31 || eb == 31) begin
            r = {s, 15'h7C00};
            return;
        end
`endif
        if (ea == 0 || eb == 0) begin
            r = {s, 15'h0};
        end else if (e >= 31) begin
            r  = {s, 15'h7C00};
            ov = 1'b1;
        end else if (e <= 0) begin
            r  = {s, 15'h0};
            un = 1'b1;
        end else begin
            r = {s, 5'(e), m};
        end
    endfunction

    // Expected port values, advanced once per rising edge.
    logic        m_busy = 1'b0, m_done = 1'b0, m_ov = 1'b0, m_un = 1'b0;
    logic [15:0] m_res = '0, m_a = '0, m_b = '0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_ov = 1'b0; m_un = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    fp_mul(m_a, m_b, m_res, m_ov, m_un);
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_left = 14;
                m_a    = op_a;
                m_b    = op_b;
                m_ov   = 1'b0;
                m_un   = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 16'(busy), 16'(m_busy));
        chk("done", 16'(done), 16'(m_done));
        chk("result", result, m_res);
        chk("overflow", 16'(overflow), 16'(m_ov));
        chk("underflow", 16'(underflow), 16'(m_un));
        if (done) n_done_seen++;
    end

    // Call at a falling edge; returns at the falling edge where done is seen.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int ign_at,
                          input logic [15:0] exp_r, input logic exp_ov, input logic exp_un);
        int lat;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ign_at != 0 && lat == ign_at) begin
                op_a  = 16'h4400;
                op_b  = 16'h4400;
                start = 1'b1;
            end else if (ign_at != 0 && lat == ign_at + 1) begin
                start = 1'b0;
            end
        end
        chk("latency", 16'(lat), 16'd14);
        chk("lit_result", result, exp_r);
        chk("lit_overflow", 16'(overflow), 16'(exp_ov));
        chk("lit_underflow", 16'(underflow), 16'(exp_un));
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
    } vec_t;

    initial begin
        vec_t        extra[4];
        logic [15:0] xr;
        logic        xo, xu;
        int          d0;

        extra[0] = '{16'h3555, 16'h4A3C};
        extra[1] = '{16'hB7FF, 16'h37FF};
        extra[2] = '{16'h2001, 16'hD3FF};
        extra[3] = '{16'h1000, 16'h1000};

        repeat (3) @(negedge clk);
        chk("reset_busy", 16'(busy), 16'd0);
        chk("reset_result", result, 16'h0000);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h3E00, 16'h3E00, 0, 16'h4080, 1'b0, 1'b0);
        @(negedge clk);
        run_op(16'hC000, 16'h4200, 0, 16'hC600, 1'b0, 1'b0);
        run_op(16'h3C00, 16'h3C00, 0, 16'h3C00, 1'b0, 1'b0);
        @(negedge clk);

        run_op(16'h7BFF, 16'h4000, 0, 16'h7C00, 1'b1, 1'b0);
        @(negedge clk);
        run_op(16'h0400, 16'h0400, 0, 16'h0000, 1'b0, 1'b1);
        @(negedge clk);
        run_op(16'h8000, 16'h3C00, 0, 16'h8000, 1'b0, 1'b0);
        @(negedge clk);
        run_op(16'h0000, 16'h4200, 0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);

        run_op(16'h4000, 16'h4200, 5, 16'h4600, 1'b0, 1'b0);
        @(negedge clk);

`ifdef FPM_NAN_INF_EN
        run_op(16'h7C00, 16'h0000, 0, 16'h7E00, 1'b0, 1'b0);
        @(negedge clk);
        run_op(16'hFC00, 16'h4000, 0, 16'hFC00, 1'b0, 1'b0);
        @(negedge clk);
        run_op(16'h7C00, 16'h3C00, 0, 16'h7C00, 1'b0, 1'b0);
        @(negedge clk);
        run_op(16'h7E01, 16'h3C00, 0, 16'h7E00, 1'b0, 1'b0);
        @(negedge clk);
`else
        run_op(16'h7C00, 16'h3C00, 0, 16'h7C00, 1'b1, 1'b0);
        @(negedge clk);
`endif

        for (int i = 0; i < 4; i++) begin
            fp_mul(extra[i].a, extra[i].b, xr, xo, xu);
            run_op(extra[i].a, extra[i].b, 0, xr, xo, xu);
            @(negedge clk);
        end

        // Mid-operation reset: outputs must clear without waiting for a clock edge.
        op_a  = 16'h3E00;
        op_b  = 16'h3E00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 16'(busy), 16'd0);
        chk("arst_done", 16'(done), 16'd0);
        chk("arst_result", result, 16'h0000);
        chk("arst_flags", {14'd0, overflow, underflow}, 16'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        d0 = n_done_seen;
        repeat (20) @(negedge clk);
        chk("no_done_after_abort", 16'(n_done_seen - d0), 16'd0);
        run_op(16'hC000, 16'h4200, 0, 16'hC600, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
